// File: rtl/icache_refill.sv
// Instruction-cache line-fill engine: fetches a whole line over a pipelined
// req/gnt/rvalid port, stores it into the cache line and returns the missed word.
module icache_refill #(
  parameter int N_CACHELINE_LENGTH = 4,
  parameter int BITSIZE            = 32,
  localparam int OFFBITS           = $clog2(N_CACHELINE_LENGTH)
) (
  input  logic                                  clk,
  input  logic                                  rstn_i,
  input  logic                                  miss_i,
  input  logic [BITSIZE-1:0]                    addr_i,
  input  logic                                  flush_i,
  output logic                                  busy_o,
  output logic                                  store_o,
  output logic [BITSIZE-1:0]                    line_addr_o,
  output logic [BITSIZE*N_CACHELINE_LENGTH-1:0] line_data_o,
  output logic                                  valid_o,
  output logic [BITSIZE-1:0]                    data_o,
  output logic                                  mem_req_o,
  output logic [BITSIZE-1:0]                    mem_addr_o,
  input  logic                                  mem_gnt_i,
  input  logic                                  mem_rvalid_i,
  input  logic [BITSIZE-1:0]                    mem_rdata_i
);

  localparam logic [OFFBITS:0] N_CNT   = (OFFBITS+1)'(N_CACHELINE_LENGTH);
  localparam logic [OFFBITS:0] CNT_ONE = (OFFBITS+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [BITSIZE-1:0]   base_r, base_s;
  logic [OFFBITS-1:0]   off_r, off_s;
  logic [OFFBITS:0]     iss_cnt_r, iss_cnt_s;
  logic [OFFBITS:0]     rcv_cnt_r, rcv_cnt_s;
  logic [BITSIZE-1:0]   buf_r [N_CACHELINE_LENGTH];
  logic                 wr_en_s;
  logic [OFFBITS-1:0]   wr_idx_s;
  logic                 req_s;
  logic                 rsp_ok_s;

  // Request is purely a function of registered state (no flush/gnt path).
  always_comb begin
    req_s    = (state_r == ST_FILL) && (iss_cnt_r < N_CNT);
    rsp_ok_s = mem_rvalid_i && (rcv_cnt_r < iss_cnt_r);
    wr_idx_s = rcv_cnt_r[OFFBITS-1:0];
  end

  // Next-state and counter update logic.
  always_comb begin
    state_s   = state_r;
    base_s    = base_r;
    off_s     = off_r;
    iss_cnt_s = iss_cnt_r;
    rcv_cnt_s = rcv_cnt_r;
    wr_en_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (miss_i && !flush_i) begin
          base_s    = {addr_i[BITSIZE-1:OFFBITS], {OFFBITS{1'b0}}};
          off_s     = addr_i[OFFBITS-1:0];
          iss_cnt_s = {(OFFBITS+1){1'b0}};
          rcv_cnt_s = {(OFFBITS+1){1'b0}};
          state_s   = ST_FILL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (req_s && mem_gnt_i) begin
          iss_cnt_s = iss_cnt_r + CNT_ONE;
        end else begin
          iss_cnt_s = iss_cnt_r;
        end
        if (rsp_ok_s) begin
          rcv_cnt_s = rcv_cnt_r + CNT_ONE;
          wr_en_s   = 1'b1;
        end else begin
          rcv_cnt_s = rcv_cnt_r;
        end
        // Flush wins over completion; DRAIN then exits at once if nothing is pending.
        if (flush_i) begin
          state_s = ST_DRAIN;
        end else if (rcv_cnt_s == N_CNT) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_DRAIN: begin
        if (rsp_ok_s) begin
          rcv_cnt_s = rcv_cnt_r + CNT_ONE;
        end else begin
          rcv_cnt_s = rcv_cnt_r;
        end
        if (rcv_cnt_s == iss_cnt_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM, line base, offset and counters.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r   <= ST_IDLE;
      base_r    <= {BITSIZE{1'b0}};
      off_r     <= {OFFBITS{1'b0}};
      iss_cnt_r <= {(OFFBITS+1){1'b0}};
      rcv_cnt_r <= {(OFFBITS+1){1'b0}};
    end else begin
      state_r   <= state_s;
      base_r    <= base_s;
      off_r     <= off_s;
      iss_cnt_r <= iss_cnt_s;
      rcv_cnt_r <= rcv_cnt_s;
    end
  end

  // Word buffer, filled in response order.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < N_CACHELINE_LENGTH; k++) begin
        buf_r[k] <= {BITSIZE{1'b0}};
      end
    end else if (wr_en_s) begin
      buf_r[wr_idx_s] <= mem_rdata_i;
    end
  end

  // Output decode from registered state.
  always_comb begin
    line_data_o = {(BITSIZE*N_CACHELINE_LENGTH){1'b0}};
    for (int k = 0; k < N_CACHELINE_LENGTH; k++) begin
      line_data_o[k*BITSIZE +: BITSIZE] = buf_r[k];
    end
    busy_o      = (state_r != ST_IDLE);
    store_o     = (state_r == ST_DONE);
    valid_o     = (state_r == ST_DONE) && !flush_i;
    data_o      = buf_r[off_r];
    line_addr_o = base_r;
    mem_req_o   = req_s;
    mem_addr_o  = base_r + BITSIZE'(iss_cnt_r);
  end

endmodule

// File: tb/tb_icache_refill.sv
// Randomized self-checking bench for icache_refill: a queue-based in-order memory
// responder plus a line/word reference model derived from the memory contents.
module tb_icache_refill;

  logic         clk;
  logic         rstn_i;
  logic         miss_i;
  logic [31:0]  addr_i;
  logic         flush_i;
  logic         busy_o;
  logic         store_o;
  logic [31:0]  line_addr_o;
  logic [127:0] line_data_o;
  logic         valid_o;
  logic [31:0]  data_o;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_gnt_i;
  logic         mem_rvalid_i;
  logic [31:0]  mem_rdata_i;

  icache_refill #(.N_CACHELINE_LENGTH(4), .BITSIZE(32)) dut (
    .clk(clk), .rstn_i(rstn_i), .miss_i(miss_i), .addr_i(addr_i), .flush_i(flush_i),
    .busy_o(busy_o), .store_o(store_o), .line_addr_o(line_addr_o), .line_data_o(line_data_o),
    .valid_o(valid_o), .data_o(data_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t         rsp_q[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  bit           gnt_rand = 1'b0;
  bit           spur_en = 1'b0;
  int           dmin = 1;
  int           dmax = 1;
  int           n_grant, n_resp, n_store, n_valid, n_req, busy_cycles;
  int           store_cyc, last_resp_cyc;
  logic [31:0]  exp_base = 32'h0;
  logic [31:0]  exp_word = 32'h0;
  logic [127:0] exp_line = 128'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_model(input logic [31:0] a);
    exp_base = {a[31:2], 2'b00};
    exp_word = mem_word(a);
    for (int k = 0; k < 4; k++) exp_line[k*32 +: 32] = mem_word(exp_base + 32'(k));
    n_grant = 0; n_resp = 0; n_store = 0; n_valid = 0; n_req = 0; busy_cycles = 0;
  endtask

  // One clock cycle: drive memory side, observe outputs, advance to next negedge.
  task automatic tick();
    rsp_t r;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      r = rsp_q.pop_front();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_word(r.addr);
      n_resp++;
      last_resp_cyc = cyc;
    end else if (spur_en && rsp_q.size() == 0 && $urandom_range(0, 3) == 0) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = $urandom;
    end
    mem_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (mem_req_o) n_req++;
    if (mem_req_o && mem_gnt_i) begin
      check_eq("mem_addr", mem_addr_o, exp_base + 32'(n_grant));
      n_grant++;
      rsp_q.push_back('{mem_addr_o, cyc + int'($urandom_range(dmin, dmax))});
    end
    if (busy_o) busy_cycles++;
    if (store_o) begin
      n_store++;
      store_cyc = cyc;
      check_eq("line_addr", line_addr_o, exp_base);
      check_eq("line_data", line_data_o, exp_line);
    end
    if (valid_o) begin
      n_valid++;
      check_eq("data_o", data_o, exp_word);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_fill(input logic [31:0] a, input bit best, input bit flush_done, input string tag);
    int  c0;
    bit  done;
    set_model(a);
    check_eq($sformatf("%s.idle_at_miss", tag), busy_o, 1'b0);
    c0     = cyc;
    miss_i = 1'b1;
    addr_i = a;
    done   = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (flush_done && store_o) flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      if (n_store > 0) done = 1'b1;
    end
    miss_i = 1'b0;
    check_eq($sformatf("%s.completed", tag), done, 1'b1);
    check_eq($sformatf("%s.stores", tag), n_store, 1);
    check_eq($sformatf("%s.valids", tag), n_valid, flush_done ? 0 : 1);
    check_eq($sformatf("%s.grants", tag), n_grant, 4);
    check_eq($sformatf("%s.resps", tag), n_resp, 4);
    if (best) begin
      check_eq($sformatf("%s.store_cycle", tag), store_cyc - c0, 6);
      check_eq($sformatf("%s.busy_cycles", tag), busy_cycles, 6);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rstn_i = 1'b0; miss_i = 1'b0; flush_i = 1'b0; addr_i = 32'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    set_model(32'h0);
    @(negedge clk);
    @(negedge clk);
    check_eq("rst.busy", busy_o, 1'b0);
    check_eq("rst.store", store_o, 1'b0);
    check_eq("rst.valid", valid_o, 1'b0);
    check_eq("rst.req", mem_req_o, 1'b0);
    check_eq("rst.mem_addr", mem_addr_o, 32'h0);
    check_eq("rst.line_data", line_data_o, 128'h0);
    check_eq("rst.data", data_o, 32'h0);
    rstn_i = 1'b1;
    tick();

    // Basic fill followed by a back-to-back miss.
    do_fill(32'h106, 1'b1, 1'b0, "basic");
    do_fill(32'h10A, 1'b1, 1'b0, "b2b");

    // Stalled grants and variable response latency, spurious rvalids mixed in.
    gnt_rand = 1'b1; dmin = 1; dmax = 3; spur_en = 1'b1;
    do_fill(32'h106, 1'b0, 1'b0, "stall_same");
    for (int t = 0; t < 8; t++) begin
      do_fill($urandom, 1'b0, 1'b0, $sformatf("rand%0d", t));
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
    end
    gnt_rand = 1'b0; dmin = 1; dmax = 1; spur_en = 1'b0;
    for (int k = 0; k < 6; k++) tick();

    // Flush mid-fill with 2 issued and 1 received.
    set_model(32'h300);
    c0 = cyc;
    miss_i = 1'b1; addr_i = 32'h300;
    tick();
    miss_i = 1'b0;
    tick();
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 50 && busy_o; i++) tick();
    check_eq("flush.busy_low", busy_o, 1'b0);
    check_eq("flush.stores", n_store, 0);
    check_eq("flush.valids", n_valid, 0);
    check_eq("flush.grants", n_grant, 3);
    check_eq("flush.resps", n_resp, n_grant);
    check_eq("flush.busy_drop_cycle", cyc, last_resp_cyc + 1);
    check_eq("flush.drop_rel", cyc - c0, 5);
    do_fill(32'h200, 1'b1, 1'b0, "after_flush");

    // Miss and flush together in IDLE.
    set_model(32'h400);
    miss_i = 1'b1; flush_i = 1'b1; addr_i = 32'h400;
    tick();
    miss_i = 1'b0; flush_i = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check_eq("missflush.reqs", n_req, 0);
    check_eq("missflush.busy", busy_o, 1'b0);

    // Flush during the DONE cycle.
    do_fill(32'h603, 1'b1, 1'b1, "flush_done");
    tick();

    // Asynchronous reset mid-fill with responses still outstanding.
    dmin = 3; dmax = 3;
    set_model(32'h500);
    miss_i = 1'b1; addr_i = 32'h501;
    tick();
    miss_i = 1'b0;
    tick();
    tick();
    rstn_i = 1'b0;
    #1;
    check_eq("arst.busy", busy_o, 1'b0);
    check_eq("arst.store", store_o, 1'b0);
    check_eq("arst.valid", valid_o, 1'b0);
    check_eq("arst.req", mem_req_o, 1'b0);
    check_eq("arst.mem_addr", mem_addr_o, 32'h0);
    check_eq("arst.line_addr", line_addr_o, 32'h0);
    check_eq("arst.line_data", line_data_o, 128'h0);
    check_eq("arst.data", data_o, 32'h0);
    tick();
    rstn_i = 1'b1;
    for (int i = 0; i < 20 && rsp_q.size() > 0; i++) tick();
    tick();
    check_eq("arst.late_drained", rsp_q.size(), 0);
    check_eq("arst.late_resps", n_resp, 2);
    check_eq("arst.no_store", n_store, 0);
    check_eq("arst.busy_after", busy_o, 1'b0);
    dmin = 1; dmax = 1;
    do_fill(32'h000, 1'b1, 1'b0, "after_rst");

    // Spurious rvalid while idle, then a fill at the last word offset.
    set_model(32'h0);
    spur_en = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    check_eq("spur.busy", busy_o, 1'b0);
    check_eq("spur.stores", n_store, 0);
    check_eq("spur.reqs", n_req, 0);
    do_fill(32'h7, 1'b1, 1'b0, "off_last");
    spur_en = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_refill.md
# icache_refill

Line-fill engine between the fetch-side cache line and instruction memory. On a fetch miss it reads one whole line (N_CACHELINE_LENGTH consecutive words) over a pipelined req/gnt/rvalid memory port and packs the words into a flat line. It then presents the packed line to the cache line's store input for one cycle and returns the missed word to the fetch stage. All addresses are word addresses; the low $clog2(N_CACHELINE_LENGTH) bits select the word within a line.

## Interface
- N_CACHELINE_LENGTH, 4, words per line; power of two, ≥2
- BITSIZE, 32, word and address width
- OFFBITS, $clog2(N_CACHELINE_LENGTH), word-offset width (derived, not overridden)

- clk  in  1  clock; all state changes on rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- miss_i  in  1  fetch missed; sampled only in IDLE
- addr_i  in  BITSIZE  missed word address; sampled with miss_i
- flush_i  in  1  abandon the current fill (branch/redirect)
- busy_o  out  1  state != IDLE
- store_o  out  1  one-cycle pulse: write line_data_o/line_addr_o into cache line
- line_addr_o  out  BITSIZE  base of filled line (offset bits zero)
- line_data_o  out  BITSIZE*N_CACHELINE_LENGTH  word k at bits [(k+1)*BITSIZE-1 : k*BITSIZE]
- valid_o  out  1  one-cycle pulse: data_o is the missed word
- data_o  out  BITSIZE  missed word
- mem_req_o  out  1  read request
- mem_addr_o  out  BITSIZE  request word address
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid; responses return in request order
- mem_rdata_i  in  BITSIZE  read data

## Operation
- Registers:
  - base (BITSIZE, offset bits zero)
  - off (OFFBITS)
  - iss_cnt, rcv_cnt (OFFBITS+1 bits each, range 0..N)
  - word buffer of N words
  - FSM
- IDLE: miss_i=1 and flush_i=0 → base = {addr_i[BITSIZE-1:OFFBITS], 0}, off = addr_i[OFFBITS-1:0], counters cleared, go to FILL. If miss_i and flush_i are both 1, flush wins and the FSM stays in IDLE.
- FILL:
  - mem_req_o = (iss_cnt < N).
  - mem_addr_o = base + iss_cnt. Words are fetched in order from base; offset bits never carry into the tag.
  - mem_req_o && mem_gnt_i → iss_cnt+1.
  - mem_rvalid_i && rcv_cnt < iss_cnt → word[rcv_cnt] = mem_rdata_i, rcv_cnt+1.
  - mem_rvalid_i with rcv_cnt == iss_cnt is spurious and ignored.
  - After the last word is received (rcv_cnt reaches N) → DONE.
  - flush_i=1 → DRAIN. A grant in the same cycle still counts as issued.
- DRAIN:
  - mem_req_o = 0.
  - Accepts responses until rcv_cnt == iss_cnt, then goes to IDLE.
  - Data is discarded; no store_o and no valid_o.
  - If rcv_cnt == iss_cnt on entry, DRAIN lasts one cycle.
- DONE (one cycle):
  - store_o = 1, line_data_o = packed buffer, line_addr_o = base.
  - valid_o = !flush_i, data_o = word[off].
  - Then IDLE. Under flush the line is still stored because it is correct data.
- miss_i while busy is ignored; the fetch stage holds it until valid_o.
- mem_addr_o and line_addr_o drive base/base+iss_cnt at all times. line_data_o always reflects the buffer.

## Timing
- Reset values:
  - FSM = IDLE; all counters, base, off and buffer = 0.
  - busy_o, store_o, valid_o, mem_req_o = 0.
  - mem_addr_o, line_addr_o, line_data_o, data_o = 0.
- Outputs are decoded from registered state. mem_req_o has no combinational path from flush_i or mem_gnt_i.
- Memory contract: rvalid for a request comes at least 1 cycle after its grant.
- Best case, with gnt always high and rvalid 1 cycle after gnt:
  - miss sampled at edge 0.
  - Requests at cycles 1..N, responses at cycles 2..N+1.
  - DONE, with store_o and valid_o, at cycle N+2.
  - busy_o high for cycles 1..N+2.
- Back-to-back misses: a new miss_i is accepted in the first IDLE cycle after DONE, i.e. one bubble.
- Asynchronous reset mid-fill: immediate return to IDLE with all outputs at their reset values. Late memory responses then arrive with rcv_cnt == iss_cnt and are ignored.

## Test plan
All scenarios use N=4, BITSIZE=32.
- Basic fill: memory holds word A = A^32'hA5A5_0000, zero-wait gnt, 1-cycle rvalid. miss at addr 0x106 →
  - mem_addr_o sequence 0x104..0x107.
  - store_o at cycle 6 with line_addr_o 0x104 and line_data_o = {mem[0x107], mem[0x106], mem[0x105], mem[0x104]}.
  - valid_o with data_o = mem[0x106].
- Stalled gnt: random gnt (50%) and 1–3-cycle rvalid delays →
  - exactly 4 requests and 4 responses.
  - identical line and word to the zero-wait case.
  - exactly one store_o and one valid_o pulse.
- Flush mid-fill: flush_i at cycle 3 with 2 issued and 1 received →
  - DRAIN consumes 1 more response.
  - no store_o or valid_o; busy_o drops after the last response.
  - next miss at 0x200 fills correctly.
- Flush boundaries:
  - miss_i and flush_i together in IDLE → no mem_req_o.
  - flush_i in the DONE cycle → store_o=1, valid_o=0.
- Reset mid-fill: rstn_i low at cycle 3 →
  - all outputs are 0 asynchronously.
  - a late rvalid after reset is ignored.
  - a following miss at 0x000 completes normally.
- Spurious, ignored and boundary inputs:
  - rvalid while IDLE, and a second miss_i while busy → no state change.
  - miss at 0x7 (offset N-1) → line at 0x4, data_o = word[3].
